wired_cdb_arbiter: RTL and testbench

Collects completed results from the two ALU pipes, the LSU and the MDU, and drives the two-lane common data bus (CDB).
- The CDB is snooped by every issue queue (cdb_i[1:0]) and written into the ROB.
- Lane k writes ROB bank k only. Arbitration is per bank with fixed priority ALU0 > ALU1 > LSU > MDU.
- An anti-starvation promotion guarantees LSU/MDU progress.
- Each source has a small input FIFO, so producers such as the LSU see a plain valid/ready handshake.

---
 rtl/wired_cdb_arbiter_if.sv | 25 ++
 rtl/wired_cdb_arbiter.sv | 98 +++++++++
 tb/tb_wired_cdb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wired_cdb_arbiter_if.sv
// rtl/wired_cdb_arbiter_if.sv - CDB result type and source/CDB bus interface
// Master is the producer/ROB side, slave is the arbiter.
package wired_cdb_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  rid;
  } pipeline_cdb_t;
endpackage

interface wired_cdb_arbiter_if;
  logic [3:0]                          src_valid_i;
  wired_cdb_pkg::pipeline_cdb_t [3:0] src_payload_i;
  logic [3:0]                          src_ready_o;
  wired_cdb_pkg::pipeline_cdb_t [1:0] cdb_o;
  logic [1:0]                          cdb_valid_o;

  modport master (
    output src_valid_i, src_payload_i,
    input  src_ready_o, cdb_o, cdb_valid_o
  );
  modport slave (
    input  src_valid_i, src_payload_i,
    output src_ready_o, cdb_o, cdb_valid_o
  );
endinterface

// File: rtl/wired_cdb_arbiter.sv
// rtl/wired_cdb_arbiter.sv - per-source FIFOs feeding a two-lane, bank-split CDB
// Fixed priority ALU0 > ALU1 > LSU > MDU per bank, with starvation promotion for LSU/MDU.
module wired_cdb_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  wired_cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef wired_cdb_pkg::pipeline_cdb_t cdb_t;

  cdb_t          r_mem   [4][BUF_DEPTH];
  logic [PW-1:0] r_head  [4];
  logic [PW-1:0] r_tail  [4];
  logic [CW-1:0] r_count [4];
  logic [SW-1:0] r_starve[2];
  cdb_t          r_cdb   [2];
  logic [1:0]    r_cdb_valid;

  logic [3:0] w_ready, w_nonempty, w_push, w_grant;
  logic [3:0] w_cand [2];
  logic [1:0] w_sel  [2];
  logic [1:0] w_win_valid;
  logic [1:0] w_promo;
  cdb_t       w_head [4];

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_ready[s]    = r_count[s] < CW'(BUF_DEPTH);
      w_nonempty[s] = r_count[s] != '0;
      w_head[s]     = r_mem[s][r_head[s]];
      w_push[s]     = bus.src_valid_i[s] & w_ready[s];
    end
    for (int j = 0; j < 2; j++) begin
      w_promo[j] = r_starve[j] == SW'(STARVE_LIMIT);
    end
  end

  // Bank k only sees heads whose rid[0] selects that bank.
  always_comb begin
    w_grant = '0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) begin
        w_cand[k][s] = w_nonempty[s] && (w_head[s].rid[0] == 1'(k));
      end
      w_win_valid[k] = |w_cand[k];
      if (w_cand[k][2] && w_promo[0])      w_sel[k] = 2'd2;
      else if (w_cand[k][3] && w_promo[1]) w_sel[k] = 2'd3;
      else if (w_cand[k][0])               w_sel[k] = 2'd0;
      else if (w_cand[k][1])               w_sel[k] = 2'd1;
      else if (w_cand[k][2])               w_sel[k] = 2'd2;
      else                                 w_sel[k] = 2'd3;
      if (w_win_valid[k]) w_grant[w_sel[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int s = 0; s < 4; s++) begin
        r_head[s]  <= '0;
        r_tail[s]  <= '0;
        r_count[s] <= '0;
      end
      for (int j = 0; j < 2; j++) r_starve[j] <= '0;
      for (int k = 0; k < 2; k++) r_cdb[k] <= '0;
      r_cdb_valid <= 2'b00;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (w_push[s]) begin
          r_mem[s][r_tail[s]] <= bus.src_payload_i[s];
          r_tail[s]           <= r_tail[s] + PW'(1);
        end
        if (w_grant[s]) r_head[s] <= r_head[s] + PW'(1);
        r_count[s] <= r_count[s] + CW'(w_push[s]) - CW'(w_grant[s]);
      end
      // Counter saturates at the limit, so promotion persists until the grant.
      for (int j = 0; j < 2; j++) begin
        if (!w_nonempty[j+2] || w_grant[j+2]) r_starve[j] <= '0;
        else if (!w_promo[j])                 r_starve[j] <= r_starve[j] + SW'(1);
      end
      for (int k = 0; k < 2; k++) begin
        r_cdb_valid[k] <= w_win_valid[k];
        if (w_win_valid[k]) r_cdb[k] <= w_head[w_sel[k]];
      end
    end
  end

  assign bus.src_ready_o = w_ready;
  assign bus.cdb_valid_o = r_cdb_valid;
  assign bus.cdb_o[0]    = r_cdb[0];
  assign bus.cdb_o[1]    = r_cdb[1];
endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// tb/tb_wired_cdb_arbiter.sv - directed self-checking bench for wired_cdb_arbiter
// data field carries the source index so lane traffic can be attributed.
module tb_wired_cdb_arbiter;
  import wired_cdb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  wired_cdb_arbiter_if bus ();

  wired_cdb_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  pipeline_cdb_t q_lane0[$];
  pipeline_cdb_t q_lane1[$];
  pipeline_cdb_t q_all[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cdb_valid_o[0]) begin q_lane0.push_back(bus.cdb_o[0]); q_all.push_back(bus.cdb_o[0]); end
      if (bus.cdb_valid_o[1]) begin q_lane1.push_back(bus.cdb_o[1]); q_all.push_back(bus.cdb_o[1]); end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pipeline_cdb_t mk(input int tag, input int rid);
    pipeline_cdb_t p;
    p.data = 32'(tag);
    p.rid  = 6'(rid);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.src_valid_i   = 4'b0000;
    bus.src_payload_i = '0;
    flush             = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    q_lane0.delete();
    q_lane1.delete();
    q_all.delete();
  endtask

  initial begin
    int a0, a1, l, acc5, n;
    logic [3:0] acc;
    pipeline_cdb_t lsu_out[$];

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    tick();
    check("rst_ready", bus.src_ready_o, 4'hf);
    check("rst_valid", bus.cdb_valid_o, 2'b00);
    check("rst_cdb", bus.cdb_o, '0);

    // 1: two banks in parallel
    do_reset();
    bus.src_valid_i = 4'b0011;
    bus.src_payload_i[0] = mk(0, 4);
    bus.src_payload_i[1] = mk(1, 7);
    tick();
    clear_inputs();
    check("t1_c1_valid", bus.cdb_valid_o, 2'b00);
    tick();
    check("t1_c2_valid", bus.cdb_valid_o, 2'b11);
    check("t1_lane0_rid", bus.cdb_o[0].rid, 4);
    check("t1_lane1_rid", bus.cdb_o[1].rid, 7);
    tick();
    check("t1_c3_valid", bus.cdb_valid_o, 2'b00);

    // 2: same-bank conflict serializes by priority
    do_reset();
    bus.src_valid_i = 4'b1101;
    bus.src_payload_i[0] = mk(0, 2);
    bus.src_payload_i[2] = mk(2, 6);
    bus.src_payload_i[3] = mk(3, 8);
    tick();
    clear_inputs();
    tick();
    check("t2_c2_valid", bus.cdb_valid_o, 2'b01);
    check("t2_c2_rid", bus.cdb_o[0].rid, 2);
    tick();
    check("t2_c3_valid", bus.cdb_valid_o, 2'b01);
    check("t2_c3_rid", bus.cdb_o[0].rid, 6);
    tick();
    check("t2_c4_valid", bus.cdb_valid_o, 2'b01);
    check("t2_c4_rid", bus.cdb_o[0].rid, 8);
    tick();
    check("t2_c5_valid", bus.cdb_valid_o, 2'b00);

    // 3: MDU starvation promotion under constant bank-0 ALU traffic
    do_reset();
    a0 = 0;
    a1 = 0;
    for (int c = 0; c < 12; c++) begin
      bus.src_valid_i[0]   = 1'b1;
      bus.src_payload_i[0] = mk(0, (2 * a0) & 62);
      bus.src_valid_i[1]   = 1'b1;
      bus.src_payload_i[1] = mk(1, (2 * a1) & 62);
      bus.src_valid_i[3]   = (c == 0);
      bus.src_payload_i[3] = mk(3, 10);
      acc = bus.src_valid_i & bus.src_ready_o;
      tick();
      if (acc[0]) a0++;
      if (acc[1]) a1++;
      if (c + 1 >= 2 && c + 1 <= 9)
        check($sformatf("t3_c%0d_alu0", c + 1), {bus.cdb_valid_o, bus.cdb_o[0].data}, {2'b01, 32'd0});
      if (c + 1 == 9) check("t3_starve_sat", dut.r_starve[1], 8);
      if (c + 1 == 10) begin
        check("t3_mdu_out", {bus.cdb_valid_o, bus.cdb_o[0].data, bus.cdb_o[0].rid}, {2'b01, 32'd3, 6'd10});
        check("t3_starve_clr", dut.r_starve[1], 0);
      end
      if (c + 1 == 11)
        check("t3_c11_alu0", {bus.cdb_valid_o, bus.cdb_o[0].data}, {2'b01, 32'd0});
    end
    clear_inputs();

    // 4: LSU backpressure with ALU1 flooding bank 1
    do_reset();
    a1 = 0;
    l = 0;
    acc5 = -1;
    for (int c = 0; c < 40; c++) begin
      bus.src_valid_i[1]   = 1'b1;
      bus.src_payload_i[1] = mk(1, (2 * a1 + 1) & 63);
      bus.src_valid_i[2]   = (l < 3);
      bus.src_payload_i[2] = mk(2, 2 * l + 1);
      acc = bus.src_valid_i & bus.src_ready_o;
      tick();
      if (acc[1]) a1++;
      if (acc[2]) begin
        if (l == 2) acc5 = c;
        l++;
      end
      if (c + 1 == 2) check("t4_full_ready", bus.src_ready_o[2], 1'b0);
      if (c + 1 == 9) check("t4_held_ready", bus.src_ready_o[2], 1'b0);
    end
    clear_inputs();
    check("t4_rid5_accept_cycle", acc5, 10);
    foreach (q_lane1[i]) if (q_lane1[i].data == 32'd2) lsu_out.push_back(q_lane1[i]);
    check("t4_lsu_count", lsu_out.size(), 3);
    for (int i = 0; i < 3 && i < lsu_out.size(); i++)
      check($sformatf("t4_order%0d", i), lsu_out[i].rid, 2 * i + 1);

    // 5: flush discards buffered and in-flight results
    do_reset();
    bus.src_valid_i = 4'b1111;
    for (int s = 0; s < 4; s++) bus.src_payload_i[s] = mk(s, 2 * s + 2);
    tick();
    clear_inputs();
    tick();
    check("t5_pre_valid", bus.cdb_valid_o, 2'b01);
    flush                = 1'b1;
    bus.src_valid_i[0]   = 1'b1;
    bus.src_payload_i[0] = mk(0, 12);
    tick();
    clear_inputs();
    check("t5_post_valid", bus.cdb_valid_o, 2'b00);
    check("t5_post_ready", bus.src_ready_o, 4'hf);
    check("t5_post_cdb", bus.cdb_o, '0);
    for (int c = 0; c < 10; c++) tick();
    check("t5_no_flushed_out", q_all.size(), 1);

    // 6: 20 LSU results alternating banks, exercising pointer wrap
    do_reset();
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      bus.src_valid_i[2]   = 1'b1;
      bus.src_payload_i[2] = mk(2, n);
      acc = bus.src_valid_i & bus.src_ready_o;
      tick();
      if (acc[2]) n++;
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) tick();
    check("t6_pushed", n, 20);
    check("t6_out_count", q_all.size(), 20);
    check("t6_lane0_count", q_lane0.size(), 10);
    for (int i = 0; i < 20 && i < q_all.size(); i++)
      check($sformatf("t6_order%0d", i), q_all[i].rid, i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
